// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - multiply-accumulate neuron with bias, ReLU and 8-bit saturation
// Accepts N_INPUTS beats, then emits one clamped result through a valid/ready handshake.
module neuron_mac #(
  parameter int N_INPUTS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic [3:0] in_weight,
  input  logic [7:0] in_bias,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_sat,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    ACCUM,
    ACT,
    OUT
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [12:0] acc;
  logic signed [12:0] acc_base;
  logic signed [12:0] product;
  logic [CW-1:0]      count;
  logic               accept;
  logic               last_beat;
  logic               acc_neg;
  logic               acc_big;
  logic               out_fire;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == LAST_COUNT);
  assign out_fire  = out_valid && out_ready;

  // Activation is zero-extended, weight sign-extended, so the product is a true signed product.
  assign product  = $signed({9'b0, in_data}) * $signed({{9{in_weight[3]}}, in_weight});
  assign acc_base = (count == '0) ? {{5{in_bias[7]}}, in_bias} : acc;

  assign acc_neg = acc[12];
  assign acc_big = !acc[12] && (|acc[11:8]);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && last_beat) state_next = ACT;
      ACT:   state_next = OUT;
      OUT:   if (out_fire) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_base + product;
            count <= last_beat ? '0 : count + CW'(1);
          end
        end
        ACT: begin
          out_valid <= 1'b1;
          out_sat   <= acc_neg || acc_big;
          if (acc_neg)      out_data <= 8'd0;
          else if (acc_big) out_data <= 8'd255;
          else              out_data <= acc[7:0];
        end
        OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
